// File: rtl/load_store_unit_if.sv
// Word-wide data-bus interface between the load/store unit (master) and
// the data memory or interconnect (slave). Read data is valid in the same
// cycle that bus_ready is high.
interface load_store_unit_if;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_we,
        output bus_addr,
        output bus_wstrb,
        output bus_wdata,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_we,
        input  bus_addr,
        input  bus_wstrb,
        input  bus_wdata,
        output bus_ready,
        output bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts a load/store request from execute, runs one
// valid/ready transaction on the word-wide data bus and returns the aligned,
// sign/zero-extended load result. The core is stalled until DONE.
// Misaligned accesses never reach the bus and are reported via misalign_err.
// Optional feature: define LSU_TIMEOUT_EN to abort a bus transaction after
// TIMEOUT_CYCLES wait cycles and report it on bus_err. Without the macro the
// unit waits for bus_ready indefinitely and bus_err is tied low.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       data_mem_out,
    output logic              stall,
    output logic              misalign_err,
    output logic              bus_err,
    load_store_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A zero limit would give a degenerate wait counter.
    if (TIMEOUT_CYCLES == 32'd0) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT_CYCLES must be nonzero");
    end

    // Byte access: SB, LB, LBU. funct3=100 is only a byte access for loads.
    function automatic logic f_is_byte(input logic we, input logic [2:0] f3);
        return (f3 == 3'b000) || (!we && (f3 == 3'b100));
    endfunction

    // Halfword access: SH, LH, LHU. Anything not byte/half is a word access.
    function automatic logic f_is_half(input logic we, input logic [2:0] f3);
        return (f3 == 3'b001) || (!we && (f3 == 3'b101));
    endfunction

    function automatic logic f_misaligned(input logic we, input logic [2:0] f3,
                                          input logic [1:0] lo);
        if (f_is_byte(we, f3)) begin
            return 1'b0;
        end else if (f_is_half(we, f3)) begin
            return lo[0];
        end else begin
            return (lo != 2'b00);
        end
    endfunction

    function automatic logic [3:0] f_wstrb(input logic we, input logic [2:0] f3,
                                           input logic [1:0] lo);
        if (!we) begin
            return 4'b0000;
        end else if (f_is_byte(we, f3)) begin
            return 4'b0001 << lo;
        end else if (f_is_half(we, f3)) begin
            return 4'b0011 << {lo[1], 1'b0};
        end else begin
            return 4'b1111;
        end
    endfunction

    // Replicate the store operand into every lane; the strobes pick the lane.
    function automatic logic [31:0] f_wdata(input logic we, input logic [2:0] f3,
                                            input logic [31:0] data);
        if (f_is_byte(we, f3)) begin
            return {4{data[7:0]}};
        end else if (f_is_half(we, f3)) begin
            return {2{data[15:0]}};
        end else begin
            return data;
        end
    endfunction

    // Select the addressed byte/halfword and extend it; funct3[2] marks unsigned.
    function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        if (f_is_byte(1'b0, f3)) begin
            return f3[2] ? {24'h00_0000, b} : {{24{b[7]}}, b};
        end else if (f_is_half(1'b0, f3)) begin
            return f3[2] ? {16'h0000, h} : {{16{h[15]}}, h};
        end else begin
            return rdata;
        end
    endfunction

    state_e      state_q;
    logic        bus_valid_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_wstrb_q;
    logic [31:0] bus_wdata_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] data_q;
    logic        misalign_err_q;

    logic        misalign_d;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] load_d;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             bus_err_q;
`endif

    // Request decode on the live inputs and load extraction on the latched request.
    always_comb begin
        misalign_d = f_misaligned(mem_write, funct3, addr[1:0]);
        wstrb_d    = f_wstrb(mem_write, funct3, addr[1:0]);
        wdata_d    = f_wdata(mem_write, funct3, store_data);
        load_d     = f_load_ext(funct3_q, addr_lo_q, bus.bus_rdata);
    end

    // Access FSM with all bus and status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            bus_valid_q    <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= 32'h0000_0000;
            bus_wstrb_q    <= 4'b0000;
            bus_wdata_q    <= 32'h0000_0000;
            funct3_q       <= 3'b000;
            addr_lo_q      <= 2'b00;
            data_q         <= 32'h0000_0000;
            misalign_err_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q     <= '0;
            bus_err_q      <= 1'b0;
`endif
        end else begin
            // Error flags are single-cycle pulses raised only on entry to DONE.
            misalign_err_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_err_q      <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (req && misalign_d) begin
                        state_q        <= ST_DONE;
                        misalign_err_q <= 1'b1;
                        if (!mem_write) begin
                            data_q <= 32'h0000_0000;
                        end
                    end else if (req) begin
                        state_q     <= ST_REQ;
                        bus_valid_q <= 1'b1;
                        bus_we_q    <= mem_write;
                        bus_addr_q  <= {addr[31:2], 2'b00};
                        bus_wstrb_q <= wstrb_d;
                        bus_wdata_q <= wdata_d;
                        funct3_q    <= funct3;
                        addr_lo_q   <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
                        wait_cnt_q  <= '0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ready) begin
                        state_q     <= ST_DONE;
                        bus_valid_q <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_wstrb_q <= 4'b0000;
                        if (!bus_we_q) begin
                            data_q <= load_d;
                        end
                    end else begin
`ifdef LSU_TIMEOUT_EN
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                        if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1)) begin
                            state_q     <= ST_DONE;
                            bus_valid_q <= 1'b0;
                            bus_we_q    <= 1'b0;
                            bus_wstrb_q <= 4'b0000;
                            bus_err_q   <= 1'b1;
                            if (!bus_we_q) begin
                                data_q <= 32'h0000_0000;
                            end
                        end else begin
                            state_q <= ST_REQ;
                        end
`else
                        state_q <= ST_REQ;
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    bus_valid_q <= 1'b0;
                    bus_we_q    <= 1'b0;
                    bus_wstrb_q <= 4'b0000;
                end
            endcase
        end
    end

    assign stall          = req & (state_q != ST_DONE);
    assign data_mem_out   = data_q;
    assign misalign_err   = misalign_err_q;
`ifdef LSU_TIMEOUT_EN
    assign bus_err        = bus_err_q;
`else
    assign bus_err        = 1'b0;
`endif
    assign bus.bus_valid  = bus_valid_q;
    assign bus.bus_we     = bus_we_q;
    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_wstrb  = bus_wstrb_q;
    assign bus.bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses compared against a byte-arithmetic reference model.
module tb_load_store_unit;

    localparam int BUDGET = 64;
`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] data_mem_out;
    logic        stall;
    logic        misalign_err;
    logic        bus_err;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .data_mem_out(data_mem_out), .stall(stall),
        .misalign_err(misalign_err), .bus_err(bus_err), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] dout_model = 32'h0;

    // Observations of the last access, filled in by run_access.
    int          obs_stall, obs_valid;
    logic        obs_done, obs_we, obs_mis, obs_berr;
    logic [31:0] obs_addr, obs_wdata, obs_dout;
    logic [3:0]  obs_wstrb;

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic w, input logic [2:0] f3);
        if (f3 == 3'b000 || (!w && f3 == 3'b100)) return 1;
        if (f3 == 3'b001 || (!w && f3 == 3'b101)) return 2;
        return 4;
    endfunction

    function automatic bit m_misaligned(input logic w, input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % acc_size(w, f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int     sz  = acc_size(1'b0, f3);
        int     off = int'(a[1:0]);
        longint v;
        v = (longint'(rd) >> (8 * off)) % (longint'(1) << (8 * sz));
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_strb(input logic w, input logic [2:0] f3, input logic [31:0] a);
        int m;
        if (!w) return 4'b0000;
        m = ((1 << acc_size(w, f3)) - 1) << int'(a[1:0]);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic w, input logic [2:0] f3, input logic [31:0] sd);
        int sz = acc_size(w, f3);
        if (sz == 1) return 32'(sd[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(sd[15:0]) * 32'h0001_0001;
        return sd;
    endfunction

    // Drive one request and act as a bus slave that answers after 'waits'
    // wait cycles. Entered and left just after a rising edge.
    task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd, input int waits);
        req = 1'b1; mem_write = w; funct3 = f3; addr = a; store_data = sd;
        bus.bus_ready = 1'b0; bus.bus_rdata = rd;
        obs_stall = 0; obs_valid = 0; obs_done = 1'b0;
        obs_we = 1'b0; obs_mis = 1'b0; obs_berr = 1'b0;
        obs_addr = 32'h0; obs_wdata = 32'h0; obs_dout = 32'h0; obs_wstrb = 4'h0;
        for (int c = 0; c < BUDGET && !obs_done; c++) begin
            @(negedge clk);
            if (stall) begin
                obs_stall++;
            end else begin
                obs_done = 1'b1;
                obs_dout = data_mem_out;
                obs_mis  = misalign_err;
                obs_berr = bus_err;
            end
            if (bus.bus_valid) begin
                obs_valid++;
                obs_addr  = bus.bus_addr;
                obs_we    = bus.bus_we;
                obs_wstrb = bus.bus_wstrb;
                obs_wdata = bus.bus_wdata;
                bus.bus_ready = (obs_valid > waits);
            end else begin
                bus.bus_ready = 1'b0;
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        bus.bus_ready = 1'b0;
        if (!obs_done) $display("FAIL run_access_budget: access did not complete in %0d cycles", BUDGET);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.bus_ready = 1'b0; bus.bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (data_mem_out !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %h want 00000000", data_mem_out); end
        n_vec++; if ({bus.bus_valid, bus.bus_we, bus.bus_wstrb} !== 6'b0) begin n_err++; $display("FAIL reset_bus_ctl: got %b want 000000", {bus.bus_valid, bus.bus_we, bus.bus_wstrb}); end
        n_vec++; if ({bus.bus_addr, bus.bus_wdata} !== 64'h0) begin n_err++; $display("FAIL reset_bus_data: got %h want 0", {bus.bus_addr, bus.bus_wdata}); end
        n_vec++; if ({stall, misalign_err, bus_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {stall, misalign_err, bus_err}); end
        @(posedge clk); #1;
    endtask

    task automatic test_lb_sign();
        run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
        dout_model = 32'hFFFF_FF80;
        n_vec++; if (obs_addr !== 32'h100) begin n_err++; $display("FAIL lb_addr: got %h want 00000100", obs_addr); end
        n_vec++; if (obs_wstrb !== 4'b0000 || obs_we !== 1'b0) begin n_err++; $display("FAIL lb_wstrb_we: got %b/%b want 0000/0", obs_wstrb, obs_we); end
        n_vec++; if (obs_dout !== dout_model) begin n_err++; $display("FAIL lb_dout: got %h want %h", obs_dout, dout_model); end
        n_vec++; if (obs_stall !== 2 || obs_valid !== 1) begin n_err++; $display("FAIL lb_timing: stall %0d valid %0d want 2 1", obs_stall, obs_valid); end
        @(negedge clk);
        n_vec++; if (data_mem_out !== dout_model) begin n_err++; $display("FAIL lb_hold: got %h want %h", data_mem_out, dout_model); end
        @(posedge clk); #1;
    endtask

    task automatic test_lhu_zero();
        run_access(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h9ABC_0000, 1);
        dout_model = 32'h0000_9ABC;
        n_vec++; if (obs_dout !== dout_model) begin n_err++; $display("FAIL lhu_dout: got %h want %h", obs_dout, dout_model); end
        n_vec++; if (obs_addr !== 32'h200) begin n_err++; $display("FAIL lhu_addr: got %h want 00000200", obs_addr); end
    endtask

    task automatic test_sb_lane();
        run_access(1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, $urandom, 0);
        n_vec++; if (obs_we !== 1'b1) begin n_err++; $display("FAIL sb_we: got %b want 1", obs_we); end
        n_vec++; if (obs_wstrb !== 4'b0010) begin n_err++; $display("FAIL sb_wstrb: got %b want 0010", obs_wstrb); end
        n_vec++; if (obs_wdata !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL sb_wdata: got %h want a5a5a5a5", obs_wdata); end
        n_vec++; if (obs_dout !== dout_model) begin n_err++; $display("FAIL sb_dout_kept: got %h want %h", obs_dout, dout_model); end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 3'b010, 32'h0000_0402, 32'h0, 32'hFFFF_FFFF, 0);
        dout_model = 32'h0;
        n_vec++; if (obs_valid !== 0) begin n_err++; $display("FAIL mis_lw_valid: got %0d cycles want 0", obs_valid); end
        n_vec++; if (obs_mis !== 1'b1 || obs_dout !== 32'h0) begin n_err++; $display("FAIL mis_lw: err %b dout %h want 1 00000000", obs_mis, obs_dout); end
        n_vec++; if (obs_stall !== 1) begin n_err++; $display("FAIL mis_lw_stall: got %0d want 1", obs_stall); end
        @(negedge clk);
        n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_pulse_len: got %b want 0", misalign_err); end
        @(posedge clk); #1;
        run_access(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'hDEAD_BEEF, 0);
        dout_model = 32'hDEAD_BEEF;
        n_vec++; if (obs_dout !== dout_model) begin n_err++; $display("FAIL lw_dout: got %h want %h", obs_dout, dout_model); end
        run_access(1'b1, 3'b001, 32'h0000_0505, 32'h1111_2222, 32'h0, 0);
        n_vec++; if (obs_mis !== 1'b1 || obs_valid !== 0 || obs_dout !== dout_model) begin n_err++; $display("FAIL mis_sh: err %b valid %0d dout %h want 1 0 %h", obs_mis, obs_valid, obs_dout, dout_model); end
    endtask

    task automatic test_wait_states();
        run_access(1'b1, 3'b010, 32'h0000_0610, 32'hCAFE_F00D, 32'h0, 3);
        n_vec++; if (obs_valid !== 4) begin n_err++; $display("FAIL ws_valid_cycles: got %0d want 4", obs_valid); end
        n_vec++; if (obs_stall !== 5) begin n_err++; $display("FAIL ws_stall_cycles: got %0d want 5", obs_stall); end
        n_vec++; if (obs_wstrb !== 4'b1111 || obs_wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL ws_sw_lanes: got %b %h want 1111 cafef00d", obs_wstrb, obs_wdata); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        run_access(1'b0, 3'b010, 32'h0000_0700, 32'h0, 32'h1234_5678, 1000);
        dout_model = 32'h0;
        n_vec++; if (obs_valid !== 4 || obs_stall !== 5) begin n_err++; $display("FAIL tmo_timing: valid %0d stall %0d want 4 5", obs_valid, obs_stall); end
        n_vec++; if (obs_berr !== 1'b1 || obs_dout !== 32'h0) begin n_err++; $display("FAIL tmo_result: berr %b dout %h want 1 00000000", obs_berr, obs_dout); end
        @(negedge clk);
        n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL tmo_pulse_len: got %b want 0", bus_err); end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_long_wait();
        run_access(1'b0, 3'b001, 32'h0000_0702, 32'h0, 32'h8001_0000, 20);
        dout_model = 32'hFFFF_8001;
        n_vec++; if (obs_valid !== 21 || obs_berr !== 1'b0) begin n_err++; $display("FAIL long_wait: valid %0d berr %b want 21 0", obs_valid, obs_berr); end
        n_vec++; if (obs_dout !== dout_model) begin n_err++; $display("FAIL long_wait_dout: got %h want %h", obs_dout, dout_model); end
    endtask
`endif

    task automatic test_back_to_back();
        run_access(1'b0, 3'b100, 32'h0000_0803, 32'h0, 32'hF0AA_5511, 0);
        n_vec++; if (obs_dout !== 32'h0000_00F0) begin n_err++; $display("FAIL b2b_lbu: got %h want 000000f0", obs_dout); end
        run_access(1'b0, 3'b001, 32'h0000_0806, 32'h0, 32'h7FFF_0000, 0);
        dout_model = 32'h0000_7FFF;
        n_vec++; if (obs_dout !== dout_model || obs_stall !== 2) begin n_err++; $display("FAIL b2b_lh: dout %h stall %0d want %h 2", obs_dout, obs_stall, dout_model); end
    endtask

    task automatic test_reset_mid();
        req = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0900;
        bus.bus_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (bus.bus_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_in_req: valid %b want 1", bus.bus_valid); end
        #2 rst_n = 1'b0;
        #1;
        dout_model = 32'h0;
        n_vec++; if (bus.bus_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid_async: got %b want 0", bus.bus_valid); end
        n_vec++; if (data_mem_out !== 32'h0) begin n_err++; $display("FAIL rstmid_dout: got %h want 00000000", data_mem_out); end
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.bus_valid !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: valid %b stall %b want 0 0", bus.bus_valid, stall); end
        @(posedge clk); #1;
        run_access(1'b0, 3'b000, 32'h0000_0a00, 32'h0, 32'h0000_0042, 0);
        dout_model = 32'h0000_0042;
        n_vec++; if (obs_stall !== 2 || obs_dout !== dout_model) begin n_err++; $display("FAIL rstmid_restart: stall %0d dout %h want 2 %h", obs_stall, obs_dout, dout_model); end
    endtask

    task automatic test_random();
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a, sd, rd;
        int          waits, sz;
        bit          mis;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; sd = $urandom; rd = $urandom;
            sz = acc_size(w, f3);
            if ($urandom_range(0, 2) != 0) a = a & ~(32'(sz) - 32'd1);
            waits = $urandom_range(0, 3);
            mis = m_misaligned(w, f3, a);
            run_access(w, f3, a, sd, rd, waits);
            if (mis) begin
                if (!w) dout_model = 32'h0;
                n_vec++; if (obs_mis !== 1'b1 || obs_valid !== 0 || obs_stall !== 1) begin n_err++; $display("FAIL rnd_mis[%0d]: err %b valid %0d stall %0d want 1 0 1", i, obs_mis, obs_valid, obs_stall); end
            end else begin
                if (!w) dout_model = m_load(f3, a, rd);
                n_vec++; if (obs_mis !== 1'b0 || obs_valid !== waits + 1 || obs_stall !== waits + 2) begin n_err++; $display("FAIL rnd_timing[%0d]: err %b valid %0d stall %0d want 0 %0d %0d", i, obs_mis, obs_valid, obs_stall, waits + 1, waits + 2); end
                n_vec++; if (obs_addr !== {a[31:2], 2'b00} || obs_we !== w) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h/%b want %h/%b", i, obs_addr, obs_we, {a[31:2], 2'b00}, w); end
                n_vec++; if (obs_wstrb !== m_strb(w, f3, a)) begin n_err++; $display("FAIL rnd_wstrb[%0d]: got %b want %b", i, obs_wstrb, m_strb(w, f3, a)); end
                if (w) begin
                    n_vec++; if (obs_wdata !== m_wdata(w, f3, sd)) begin n_err++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, obs_wdata, m_wdata(w, f3, sd)); end
                end
            end
            n_vec++; if (obs_dout !== dout_model || obs_berr !== 1'b0 || obs_done !== 1'b1) begin n_err++; $display("FAIL rnd_dout[%0d]: got %h berr %b done %b want %h 0 1", i, obs_dout, obs_berr, obs_done, dout_model); end
        end
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_lhu_zero();
        test_sb_lane();
        test_misaligned();
        test_wait_states();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access unit for the RV32I core. It sits between the execute stage and the data bus. It accepts a load or store request using the ALU address, the rs2 store data and funct3. It runs a valid/ready transaction on a word-wide data bus and produces the aligned, sign- or zero-extended load result that the writeback stage selects as its data-memory input. The core pipeline is stalled until the access completes.

## Interface
- `TIMEOUT_CYCLES`, 16: bus-wait limit; used only when the timeout feature is compiled in.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req` input 1: access request. Held stable with all request inputs while `stall`=1.
- `mem_write` input 1: 1 = store, 0 = load.
- `funct3` input 3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - any other value is treated as a word access
- `addr` input 32: byte address from the ALU.
- `store_data` input 32: rs2 value.
- `data_mem_out` output 32: extended load result; valid in the DONE cycle and held until the next load completes.
- `stall` output 1: freeze the core.
- `misalign_err` output 1: one-cycle pulse in DONE for a misaligned access.
- `bus_err` output 1: one-cycle pulse in DONE on timeout (timeout feature only).
- `bus_valid` output 1: bus request.
- `bus_ready` input 1: bus accept/complete; read data is valid in the same cycle.
- `bus_we` output 1: bus write enable.
- `bus_addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wstrb` output 4: byte enables.
- `bus_wdata` output 32: store data replicated into lanes.
- `bus_rdata` input 32: read data.

## Operation
- **FSM states:** IDLE, REQ, DONE. Reset state is IDLE.
- **IDLE:**
  - `req`=1 and access aligned: latch `mem_write`, `funct3`, `addr`, `store_data`, then go to REQ.
  - `req`=1 and access misaligned: go to DONE with the misalign flag set; no bus activity.
  - `req`=0: stay in IDLE.
- **REQ:**
  - `bus_valid`=1 and bus outputs are driven from the latched request.
  - On `bus_ready`=1: capture the extended `bus_rdata` for a load, then go to DONE.
  - A store leaves `data_mem_out` unchanged.
- **DONE:** `stall`=0 and the error pulses are asserted as applicable. The next state is IDLE unconditionally; a new `req` is sampled in IDLE.
- **Stall:** `stall` = `req` & (state != DONE), combinational.
- **Misalignment rules:**
  - halfword access with `addr[0]`=1 is misaligned.
  - word access with `addr[1:0]`≠0 is misaligned.
  - a misaligned load writes `data_mem_out` = 0.
- **Store lanes:**
  - SB: `bus_wstrb` = 0001 shifted left by `addr[1:0]`; `bus_wdata` = byte replicated ×4.
  - SH: `bus_wstrb` = 0011 shifted left by `addr[1]`×2; `bus_wdata` = halfword replicated ×2.
  - SW: `bus_wstrb` = 1111.
  - loads: `bus_wstrb` = 0000.
- **Load extraction:**
  - select the byte at `addr[1:0]` or the halfword at `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Idle outputs:** while not in REQ, `bus_valid`=0, `bus_we`=0, `bus_wstrb`=0.
- **Reset values:** FSM IDLE, `data_mem_out`=0, `bus_valid`=0, `bus_we`=0, `bus_wstrb`=0, `bus_addr`=0, `bus_wdata`=0, `misalign_err`=0, `bus_err`=0.
- **Reset mid-operation:** `bus_valid` drops immediately (asynchronous) and the FSM returns to IDLE. The transaction is abandoned.

## Timing
- **Aligned access with zero wait states:**
  - req in cycle 0 (IDLE), REQ in cycle 1 with `bus_ready`=1, DONE in cycle 2.
  - `stall` is high in cycles 0–1.
  - `data_mem_out` is valid from cycle 2.
- **Wait states:** each cycle in REQ with `bus_ready`=0 adds one cycle.
- **Misaligned access:** req in cycle 0, DONE in cycle 1 with `misalign_err`=1; `stall` is high only in cycle 0.
- **Request inputs:** sampled only in IDLE; changes while in REQ or DONE are ignored.
- **Back-to-back:** minimum spacing is one IDLE cycle between accesses (DONE → IDLE → REQ).

## Configuration
- Macro `LSU_TIMEOUT_EN`.
- **Defined:** a wait counter clears on entering REQ and increments each REQ cycle with `bus_ready`=0.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to DONE with `bus_err`=1, and a load writes `data_mem_out` = 0.
  - The counter is 0 at reset.
- **Undefined:** there is no counter, `bus_err` is tied to 0, and REQ waits indefinitely.

## Test plan
- **LB, sign extension:** LB `addr`=0x103, `bus_rdata`=0x80FF_1234, `bus_ready` high in the REQ cycle.
  - `bus_addr`=0x100, `bus_wstrb`=0000.
  - `data_mem_out`=0xFFFF_FF80 in cycle 2; `stall` high for exactly 2 cycles.
- **LHU, zero extension:** LHU `addr`=0x202, `bus_rdata`=0x9ABC_0000 → `data_mem_out`=0x0000_9ABC.
- **SB lane selection:** SB `addr`=0x301, `store_data`=0x1234_56A5 → `bus_we`=1, `bus_wstrb`=0010, `bus_wdata`=0xA5A5_A5A5.
- **Misaligned LW:** LW `addr`=0x0402 → no `bus_valid`; `misalign_err` pulses in cycle 1; `data_mem_out`=0; `stall` low in cycle 1.
- **Wait states:** SW with `bus_ready` held low for 3 REQ cycles → `bus_valid` high 4 cycles; `stall` low first in the DONE cycle.
  - With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `bus_ready` never asserted → `bus_err` pulses after 4 REQ cycles.
- **Reset mid-operation:** assert `rst_n`=0 mid-REQ → `bus_valid`=0 with no clock edge.
  - After release: FSM in IDLE and `data_mem_out`=0.
